// File: rtl/gray2binary_seq.sv
`default_nettype none
// ============================================================================
// Module      : gray2binary_seq
// Description : Bit-serial Gray-to-binary decoder. It decodes one bit per
//               clock, MSB first, with a running XOR
//               (b[i] = b[i+1] ^ g[i], b[DW] = 0).
//               It uses a valid/ready handshake on both the input and the
//               output side.
//               Accept edge E0 -> out_valid is high from edge E0+DW.
//               With out_ready held high, one word completes every DW+2
//               cycles.
// Ports       : clk       - system clock, rising edge
//               rst_n     - synchronous active-low reset
//               in_valid  - in_gray is valid
//               in_ready  - block can accept a word (IDLE only)
//               in_gray   - Gray-coded input word [DW-1:0]
//               out_valid - out_bin holds a decoded result (DONE)
//               out_ready - downstream accepts the result
//               out_bin   - decoded binary word [DW-1:0]
//               busy      - high in BUSY or DONE
//               err       - sequence-check flag (GRAY2BIN_SEQCHK_EN only)
// Options     : `define GRAY2BIN_SEQCHK_EN adds the err port. err is set
//               when consecutive accepted words differ in more than one bit.
// Parameters  : DW - data width, 2..32 (default 4)
// Revision    : 1.0 - initial release
// ============================================================================
module gray2binary_seq #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_gray,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_bin,
    output logic          busy
`ifdef GRAY2BIN_SEQCHK_EN
    ,
    output logic          err
`endif
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [DW-1:0] r_gray;
    logic [DW-1:0] r_work;
    logic [DW-1:0] r_out_bin;
    logic [DW-1:0] w_work_next;
    logic [CW-1:0] r_cnt;
    logic          r_prev;
    logic          w_bit;
    logic          w_accept;
    logic          w_out_hs;

    assign w_accept = in_valid & in_ready;
    assign w_out_hs = out_valid & out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)        w_next_state = S_BUSY;
            S_BUSY:  if (r_cnt == '0)     w_next_state = S_DONE;
            S_DONE:  if (w_out_hs)        w_next_state = S_IDLE;
            default:                      w_next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        busy      = (r_state == S_BUSY) || (r_state == S_DONE);
    end

    // Current decoded bit, and the working word with that bit written in.
    // This lets the final step load out_bin in the same cycle that it
    // writes bit 0.
    always_comb begin
        w_bit            = r_prev ^ r_gray[r_cnt];
        w_work_next      = r_work;
        w_work_next[r_cnt] = w_bit;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gray    <= '0;
            r_work    <= '0;
            r_out_bin <= '0;
            r_cnt     <= '0;
            r_prev    <= 1'b0;
        end else if (w_accept) begin
            r_gray <= in_gray;
            r_work <= '0;
            r_cnt  <= CW'(DW - 1);
            r_prev <= 1'b0;
        end else if (r_state == S_BUSY) begin
            r_work <= w_work_next;
            r_prev <= w_bit;
            r_cnt  <= r_cnt - CW'(1);
            if (r_cnt == '0) begin
                r_out_bin <= w_work_next;
            end
        end
    end

    assign out_bin = r_out_bin;

`ifdef GRAY2BIN_SEQCHK_EN
    logic [DW-1:0] r_last_gray;
    logic [DW-1:0] w_diff;
    logic [5:0]    w_dist;
    logic          r_seen;
    logic          r_err;

    // Hamming distance to the previously accepted word
    always_comb begin
        w_diff = in_gray ^ r_last_gray;
        w_dist = '0;
        for (int i = 0; i < DW; i++) begin
            w_dist = w_dist + {5'd0, w_diff[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_gray <= '0;
            r_seen      <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_accept) begin
            r_last_gray <= in_gray;
            r_seen      <= 1'b1;
            // The first word has no predecessor, so it never flags.
            r_err       <= r_seen && (w_dist > 6'd1);
        end
    end

    assign err = r_err & out_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray2binary_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray2binary_seq
// Description : Scoreboard bench for gray2binary_seq. It uses a DW=4
//               instance and a DW=8 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray2binary_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       v4, ir4, ov4, ordy4, busy4;
    logic [3:0] g4, b4;
    logic       v8, ir8, ov8, ordy8, busy8;
    logic [7:0] g8, b8;
`ifdef GRAY2BIN_SEQCHK_EN
    logic       err4, err8;
    logic       qe4[$];
    logic [3:0] m_last;
    bit         m_seen;
`endif

    gray2binary_seq #(.DW(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4), .in_gray(g4),
        .out_valid(ov4), .out_ready(ordy4), .out_bin(b4), .busy(busy4)
`ifdef GRAY2BIN_SEQCHK_EN
        , .err(err4)
`endif
    );

    gray2binary_seq #(.DW(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .in_gray(g8),
        .out_valid(ov8), .out_ready(ordy8), .out_bin(b8), .busy(busy8)
`ifdef GRAY2BIN_SEQCHK_EN
        , .err(err8)
`endif
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_acc = -1;
    int         acc4 = 0;
    bit         chk_spacing = 0;
    logic [3:0] q4[$];
    logic [7:0] q8[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor and accept tracker. The handshake happens on the
    // following posedge.
    always @(negedge clk) begin
        if (rst_n && ov4 && ordy4) begin
            if (q4.size() == 0) check("dut4_unexpected_out", 32'(b4), 32'hFFFF_FFFF);
            else                check("dut4_out_bin", 32'(b4), 32'(q4.pop_front()));
`ifdef GRAY2BIN_SEQCHK_EN
            if (qe4.size() != 0) check("dut4_err", 32'(err4), 32'(qe4.pop_front()));
`endif
        end
        if (rst_n && ov8 && ordy8) begin
            if (q8.size() == 0) check("dut8_unexpected_out", 32'(b8), 32'hFFFF_FFFF);
            else                check("dut8_out_bin", 32'(b8), 32'(q8.pop_front()));
        end
        if (rst_n && v4 && ir4) begin
            acc4++;
            if (chk_spacing && last_acc >= 0) check("accept_spacing", 32'(cyc - last_acc), 32'd6);
            last_acc = cyc;
        end
    end

    task automatic model_clear();
`ifdef GRAY2BIN_SEQCHK_EN
        m_seen = 0;
        m_last = '0;
`endif
    endtask

    task automatic send4(input logic [3:0] g, input logic [3:0] exp, input bit push);
        bit done = 0;
        v4 = 1'b1;
        g4 = g;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (ir4) begin
                if (push) begin
                    q4.push_back(exp);
`ifdef GRAY2BIN_SEQCHK_EN
                    qe4.push_back(m_seen && ($countones(g ^ m_last) > 1));
`endif
                end
`ifdef GRAY2BIN_SEQCHK_EN
                m_last = g;
                m_seen = 1;
`endif
                done = 1;
            end
        end
        if (!done) check("send4_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        v4 = 1'b0;
    endtask

    task automatic send8(input logic [7:0] g, input logic [7:0] exp);
        bit done = 0;
        v8 = 1'b1;
        g8 = g;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (ir8) begin
                q8.push_back(exp);
                done = 1;
            end
        end
        if (!done) check("send8_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        v8 = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((q4.size() != 0 || q8.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (q4.size() != 0 || q8.size() != 0) check("drain_timeout", 32'(q4.size() + q8.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v4 = 1'b0;
        v8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] gi;
        int         snap;
        int         k;
        rst_n = 1'b0; v4 = 0; v8 = 0; g4 = '0; g8 = '0; ordy4 = 1; ordy8 = 1;
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 32'(ir4), 32'd1);
        check("rst_out_valid", 32'(ov4), 32'd0);
        check("rst_out_bin", 32'(b4), 32'd0);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst8_out_bin", 32'(b8), 32'd0);
`ifdef GRAY2BIN_SEQCHK_EN
        check("rst_err", 32'(err4), 32'd0);
`endif
        @(posedge clk); #1;

        // Single word: latency DW, busy throughout, in_ready low until after the handshake
        send4(4'b0110, 4'b0100, 1);
        for (int n = 0; n <= 4; n++) begin
            @(negedge clk);
            check("lat_out_valid", 32'(ov4), 32'(n == 4));
            check("lat_busy", 32'(busy4), 32'd1);
            check("lat_in_ready", 32'(ir4), 32'd0);
        end
        @(negedge clk);
        check("post_hs_in_ready", 32'(ir4), 32'd1);
        check("post_hs_busy", 32'(busy4), 32'd0);
        @(posedge clk); #1;

        // Exhaustive back-to-back
        last_acc = -1;
        chk_spacing = 1;
        for (int i = 0; i < 16; i++) begin
            gi = 4'(i);
            send4(gi ^ (gi >> 1), gi, 1);
        end
        drain();
        chk_spacing = 0;

        // Backpressure
        ordy4 = 1'b0;
        send4(4'b1011, 4'b1101, 1);
        k = 0;
        while (!ov4 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("bp_out_valid_seen", 32'(ov4), 32'd1);
        snap = acc4;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            v4 = (n % 2 == 0);
            g4 = 4'($urandom);
            @(negedge clk);
            check("bp_out_bin", 32'(b4), 32'hD);
            check("bp_in_ready", 32'(ir4), 32'd0);
            check("bp_out_valid", 32'(ov4), 32'd1);
        end
        check("bp_no_accept", 32'(acc4), 32'(snap));
        @(posedge clk); #1;
        v4 = 1'b0;
        ordy4 = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_idle_in_ready", 32'(ir4), 32'd1);
        check("bp_idle_out_valid", 32'(ov4), 32'd0);
        check("bp_held_out_bin", 32'(b4), 32'hD);
        @(posedge clk); #1;

        // Reset during the 2nd BUSY cycle discards the word
        send4(4'b0101, 4'b0000, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        check("midrst_out_valid", 32'(ov4), 32'd0);
        check("midrst_out_bin", 32'(b4), 32'd0);
        check("midrst_in_ready", 32'(ir4), 32'd1);
        @(posedge clk); #1;
        send4(4'b1000, 4'b1111, 1);
        drain();

        // DW=8
        send8(8'hC0, 8'h80);
        for (int n = 0; n <= 8; n++) begin
            @(negedge clk);
            check("lat8_out_valid", 32'(ov8), 32'(n == 8));
        end
        @(posedge clk); #1;
        send8(8'h80, 8'hFF);
        drain();

`ifdef GRAY2BIN_SEQCHK_EN
        // Sequence check
        do_reset();
        send4(4'b0000, 4'b0000, 1);
        send4(4'b0001, 4'b0001, 1);
        send4(4'b0011, 4'b0010, 1);
        send4(4'b0011, 4'b0010, 1);
        send4(4'b0000, 4'b0000, 1);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
